// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the data-memory bus arbiter: bus widths, owner state
// encodings (decoded by the monitor/debug path via oOwner) and default limits.
package mem_bus_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Owner state encodings, exported on oOwner
  localparam logic [1:0] S_CPU     = 2'd0;
  localparam logic [1:0] S_HANDOFF = 2'd1;
  localparam logic [1:0] S_M1      = 2'd2;
  localparam logic [1:0] S_RETURN  = 2'd3;

  localparam int unsigned DEF_STARVE_LIMIT = 8;
  localparam int unsigned DEF_BURST_MAX    = 4;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Data-memory (Dw) bus seen by the arbiter. The arbiter is the master; the
// memory/peripheral fabric is the slave.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              write_enable;
  logic              read_enable;
  logic [BE_W-1:0]   byte_enable;
  logic [DATA_W-1:0] read_data;
  logic              ready;

  modport master (
    output address, write_data, write_enable, read_enable, byte_enable,
    input  read_data, ready
  );

  modport slave (
    input  address, write_data, write_enable, read_enable, byte_enable,
    output read_data, ready
  );

endinterface

// File: rtl/mem_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
  parameter int unsigned Max   = 1,
  parameter int unsigned Width = $clog2(Max + 1)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iClear,
  input  logic             iInc,
  output logic [Width-1:0] oCount
);

  logic [Width-1:0] count_q;

  // Count register: clear, else increment until Max is reached
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      count_q <= '0;
    end else if (iClear) begin
      count_q <= '0;
    end else if (iInc && (count_q != Width'(Max))) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign oCount = count_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the data-memory bus between the CPU (default owner) and master 1
// (DMA / debug loader). Master 1 preempts after a bounded wait and holds the
// bus for bounded bursts; single turnaround cycles separate owners.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned BURST_MAX    = DEF_BURST_MAX
) (
  input  logic              iCLK,
  input  logic              iRST,
  // CPU side (Datapath_MULTI Dw* ports)
  input  logic [DATA_W-1:0] iCPUAddress,
  input  logic [DATA_W-1:0] iCPUWriteData,
  input  logic              iCPUWriteEnable,
  input  logic              iCPUReadEnable,
  input  logic [BE_W-1:0]   iCPUByteEnable,
  output logic [DATA_W-1:0] oCPUReadData,
  output logic              oCPUStall,
  // Master 1
  input  logic              iM1Req,
  input  logic              iM1Write,
  input  logic [DATA_W-1:0] iM1Address,
  input  logic [DATA_W-1:0] iM1WriteData,
  input  logic [BE_W-1:0]   iM1ByteEnable,
  output logic              oM1Grant,
  output logic              oM1Ack,
  output logic [DATA_W-1:0] oM1ReadData,
  // Shared memory/peripheral bus
  mem_bus_arbiter_if.master dw,
  output logic [1:0]        oOwner
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BEAT_W   = $clog2(BURST_MAX + 1);

  logic [1:0]          state_q, state_d;
  logic [1:0]          mux_state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                cpu_access;
  logic                starve_full;
  logic                preempt;
  logic                m1_beat;
  logic                last_beat;
  logic                starve_inc;
  logic                enter_m1;

  // Qualifiers shared by the FSM, the counters and the bus mux
  always_comb begin
    cpu_access  = iCPUReadEnable | iCPUWriteEnable;
    starve_full = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    preempt     = iRST & iM1Req & starve_full;
    m1_beat     = iRST & (state_q == S_M1) & iM1Req & dw.ready;
    last_beat   = m1_beat & ((32'(beat_cnt) + 32'd1) == BURST_MAX);
    // Reset must look like S_CPU immediately, even before the async clear lands
    mux_state   = iRST ? state_q : S_CPU;
  end

  // Next owner; bus wait states never move the FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CPU:     if (iM1Req && (!cpu_access || starve_full)) state_d = S_HANDOFF;
      S_HANDOFF: state_d = S_M1;
      S_M1:      if (!iM1Req || last_beat) state_d = S_RETURN;
      S_RETURN:  state_d = S_CPU;
      default:   state_d = S_CPU;
    endcase
  end

  // Owner state register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= S_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter controls: both counters restart on the cycle that enters S_M1
  always_comb begin
    enter_m1   = (state_q == S_HANDOFF);
    starve_inc = (state_q == S_CPU) & iM1Req & (state_d == S_CPU);
  end

  arb_sat_counter #(
    .Max   (STARVE_LIMIT),
    .Width (STARVE_W)
  ) u_starve_cnt (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iClear (enter_m1),
    .iInc   (starve_inc),
    .oCount (starve_cnt)
  );

  arb_sat_counter #(
    .Max   (BURST_MAX),
    .Width (BEAT_W)
  ) u_beat_cnt (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iClear (enter_m1),
    .iInc   (m1_beat),
    .oCount (beat_cnt)
  );

  // Bus mux, stall and master-1 handshake; CPU values are the idle default
  always_comb begin
    dw.address      = iCPUAddress;
    dw.write_data   = iCPUWriteData;
    dw.byte_enable  = iCPUByteEnable;
    dw.write_enable = 1'b0;
    dw.read_enable  = 1'b0;
    oCPUReadData    = dw.read_data;
    oCPUStall       = cpu_access;
    oM1Grant        = 1'b0;
    oM1Ack          = 1'b0;
    oM1ReadData     = '0;
    case (mux_state)
      S_CPU: begin
        // On the preemption cycle the CPU access is held off, enables stay 0
        if (!preempt) begin
          dw.write_enable = iCPUWriteEnable;
          dw.read_enable  = iCPUReadEnable;
          oCPUStall       = cpu_access & ~dw.ready;
        end
      end
      S_M1: begin
        dw.address      = iM1Address;
        dw.write_data   = iM1WriteData;
        dw.byte_enable  = iM1ByteEnable;
        dw.write_enable = iM1Req & iM1Write;
        dw.read_enable  = iM1Req & ~iM1Write;
        oM1Grant        = 1'b1;
        oM1Ack          = m1_beat;
        oM1ReadData     = dw.read_data;
      end
      default: ;
    endcase
  end

  assign oOwner = mux_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (STARVE_LIMIT=8, BURST_MAX=4).
// Inputs change 1 time unit after the rising edge; outputs sampled on the
// falling edge.
module tb_mem_bus_arbiter;

  logic        iCLK;
  logic        iRST;
  logic [31:0] iCPUAddress;
  logic [31:0] iCPUWriteData;
  logic        iCPUWriteEnable;
  logic        iCPUReadEnable;
  logic [3:0]  iCPUByteEnable;
  logic [31:0] oCPUReadData;
  logic        oCPUStall;
  logic        iM1Req;
  logic        iM1Write;
  logic [31:0] iM1Address;
  logic [31:0] iM1WriteData;
  logic [3:0]  iM1ByteEnable;
  logic        oM1Grant;
  logic        oM1Ack;
  logic [31:0] oM1ReadData;
  logic [1:0]  oOwner;

  int n_checks;
  int n_errors;

  mem_bus_arbiter_if dw ();

  mem_bus_arbiter #(
    .STARVE_LIMIT (8),
    .BURST_MAX    (4)
  ) dut (
    .iCLK            (iCLK),
    .iRST            (iRST),
    .iCPUAddress     (iCPUAddress),
    .iCPUWriteData   (iCPUWriteData),
    .iCPUWriteEnable (iCPUWriteEnable),
    .iCPUReadEnable  (iCPUReadEnable),
    .iCPUByteEnable  (iCPUByteEnable),
    .oCPUReadData    (oCPUReadData),
    .oCPUStall       (oCPUStall),
    .iM1Req          (iM1Req),
    .iM1Write        (iM1Write),
    .iM1Address      (iM1Address),
    .iM1WriteData    (iM1WriteData),
    .iM1ByteEnable   (iM1ByteEnable),
    .oM1Grant        (oM1Grant),
    .oM1Ack          (oM1Ack),
    .oM1ReadData     (oM1ReadData),
    .dw              (dw),
    .oOwner          (oOwner)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic settle();
    @(negedge iCLK);
  endtask

  // Expected per-cycle owner/ack for a 6-beat read burst with BURST_MAX=4
  int exp_owner [14] = '{0, 1, 2, 2, 2, 2, 3, 0, 1, 2, 2, 2, 3, 0};
  int exp_ack   [14] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};

  initial begin
    int beat;
    n_checks        = 0;
    n_errors        = 0;
    iRST            = 1'b0;
    iCPUAddress     = '0;
    iCPUWriteData   = '0;
    iCPUWriteEnable = 1'b0;
    iCPUReadEnable  = 1'b0;
    iCPUByteEnable  = 4'hF;
    iM1Req          = 1'b0;
    iM1Write        = 1'b0;
    iM1Address      = '0;
    iM1WriteData    = '0;
    iM1ByteEnable   = 4'hF;
    dw.ready        = 1'b1;
    dw.read_data    = 32'h5555_AAAA;

    // Reset state
    repeat (2) @(posedge iCLK);
    settle();
    check("rst_owner", oOwner, 0);
    check("rst_grant", oM1Grant, 0);
    check("rst_ack", oM1Ack, 0);
    check("rst_m1rdata", oM1ReadData, 0);
    tick();
    iRST = 1'b1;

    // CPU read with three wait states
    iCPUReadEnable = 1'b1;
    iCPUAddress    = 32'h0040_0010;
    dw.ready       = 1'b0;
    dw.read_data   = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("wait_stall[%0d]", i), oCPUStall, 1);
      check($sformatf("wait_re[%0d]", i), dw.read_enable, 1);
      check($sformatf("wait_owner[%0d]", i), oOwner, 0);
      tick();
    end
    dw.ready = 1'b1;
    settle();
    check("wait_done_stall", oCPUStall, 0);
    check("wait_done_rdata", oCPUReadData, 32'h0000_0013);
    tick();
    iCPUReadEnable = 1'b0;

    // Master-1 single write with the CPU idle
    iM1Req       = 1'b1;
    iM1Write     = 1'b1;
    iM1Address   = 32'h1001_0010;
    iM1WriteData = 32'hDEAD_BEEF;
    settle();
    check("wr_t0_owner", oOwner, 0);
    check("wr_t0_we", dw.write_enable, 0);
    tick();
    settle();
    check("wr_t1_owner", oOwner, 1);
    check("wr_t1_we", dw.write_enable, 0);
    check("wr_t1_grant", oM1Grant, 0);
    tick();
    settle();
    check("wr_t2_owner", oOwner, 2);
    check("wr_t2_grant", oM1Grant, 1);
    check("wr_t2_ack", oM1Ack, 1);
    check("wr_t2_we", dw.write_enable, 1);
    check("wr_t2_addr", dw.address, 32'h1001_0010);
    check("wr_t2_data", dw.write_data, 32'hDEAD_BEEF);
    tick();
    iM1Req = 1'b0;
    settle();
    check("wr_t3_owner", oOwner, 2);
    check("wr_t3_ack", oM1Ack, 0);
    check("wr_t3_we", dw.write_enable, 0);
    tick();
    settle();
    check("wr_t4_owner", oOwner, 3);
    tick();
    settle();
    check("wr_t5_owner", oOwner, 0);
    tick();

    // Preemption: CPU reads every cycle while master 1 waits
    iCPUReadEnable = 1'b1;
    iCPUAddress    = 32'h1001_0004;
    iM1Req         = 1'b1;
    iM1Write       = 1'b0;
    iM1Address     = 32'h1001_0020;
    dw.read_data   = 32'h0000_0042;
    for (int i = 0; i < 8; i++) begin
      settle();
      check($sformatf("starve_owner[%0d]", i), oOwner, 0);
      check($sformatf("starve_re[%0d]", i), dw.read_enable, 1);
      check($sformatf("starve_stall[%0d]", i), oCPUStall, 0);
      tick();
    end
    settle();
    check("preempt_re", dw.read_enable, 0);
    check("preempt_stall", oCPUStall, 1);
    check("preempt_owner", oOwner, 0);
    tick();
    settle();
    check("preempt_ho_owner", oOwner, 1);
    check("preempt_ho_stall", oCPUStall, 1);
    check("preempt_ho_grant", oM1Grant, 0);
    tick();
    settle();
    check("preempt_m1_owner", oOwner, 2);
    check("preempt_m1_grant", oM1Grant, 1);
    check("preempt_m1_stall", oCPUStall, 1);
    check("preempt_m1_ack", oM1Ack, 1);
    check("preempt_m1_rdata", oM1ReadData, 32'h0000_0042);
    check("preempt_m1_addr", dw.address, 32'h1001_0020);
    tick();
    iM1Req         = 1'b0;
    iCPUReadEnable = 1'b0;
    settle();
    check("preempt_end_ack", oM1Ack, 0);
    tick();
    settle();
    check("preempt_ret_owner", oOwner, 3);
    tick();
    settle();
    check("preempt_cpu_owner", oOwner, 0);
    tick();

    // Six-beat read burst split across two grants
    iM1Req   = 1'b1;
    iM1Write = 1'b0;
    beat     = 0;
    for (int c = 0; c < 14; c++) begin
      iM1Address   = 32'h1002_0000 + 32'(4 * beat);
      dw.read_data = 32'h0000_1000 + 32'(beat);
      settle();
      check($sformatf("burst_owner[%0d]", c), oOwner, 32'(exp_owner[c]));
      check($sformatf("burst_ack[%0d]", c), oM1Ack, 32'(exp_ack[c]));
      if (exp_ack[c] != 0) begin
        check($sformatf("burst_rdata[%0d]", c), oM1ReadData, 32'h0000_1000 + 32'(beat));
        beat++;
      end
      tick();
      if (beat == 6) iM1Req = 1'b0;
    end

    // Request withdrawn during the handoff cycle
    iM1Req = 1'b1;
    settle();
    check("drop_t0_owner", oOwner, 0);
    tick();
    iM1Req = 1'b0;
    settle();
    check("drop_t1_owner", oOwner, 1);
    tick();
    settle();
    check("drop_t2_owner", oOwner, 2);
    check("drop_t2_grant", oM1Grant, 1);
    check("drop_t2_ack", oM1Ack, 0);
    check("drop_t2_re", dw.read_enable, 0);
    check("drop_t2_we", dw.write_enable, 0);
    tick();
    settle();
    check("drop_t3_owner", oOwner, 3);
    tick();
    settle();
    check("drop_t4_owner", oOwner, 0);
    tick();

    // Reset asserted mid-burst with beat_cnt = 2
    iM1Req   = 1'b1;
    iM1Write = 1'b0;
    dw.ready = 1'b1;
    tick();
    tick();
    settle();
    check("mid_b1_ack", oM1Ack, 1);
    tick();
    settle();
    check("mid_b2_ack", oM1Ack, 1);
    tick();
    dw.ready       = 1'b0;
    iCPUReadEnable = 1'b1;
    iCPUAddress    = 32'h1001_0000;
    dw.read_data   = 32'h0BAD_F00D;
    #1;
    check("mid_pre_owner", oOwner, 2);
    iRST     = 1'b0;
    dw.ready = 1'b1;
    #1;
    check("mid_rst_owner", oOwner, 0);
    check("mid_rst_grant", oM1Grant, 0);
    check("mid_rst_ack", oM1Ack, 0);
    check("mid_rst_m1rdata", oM1ReadData, 0);
    check("mid_rst_addr", dw.address, 32'h1001_0000);
    check("mid_rst_re", dw.read_enable, 1);
    check("mid_rst_cpurdata", oCPUReadData, 32'h0BAD_F00D);
    check("mid_rst_stall", oCPUStall, 0);
    tick();
    iRST = 1'b1;
    settle();
    check("post_rst_owner", oOwner, 0);
    check("post_rst_grant", oM1Grant, 0);
    check("post_rst_ack", oM1Ack, 0);
    check("post_rst_re", dw.read_enable, 1);
    check("post_rst_addr", dw.address, 32'h1001_0000);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
